// File: rtl/shift_pkg.sv
// Shared types for the sequential shifter: operation modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One partial shift of a WIDTH word by 0..STEP bits in the requested mode.
// Define ROTATE_EN to build mode 11 as rotate-right; otherwise mode 11 behaves as SRL.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [SW-1:0]    amt,
    input  logic [1:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // Ones in the vacated MSB positions, used only for arithmetic right shifts.
        fill_mask = fill ? ~({WIDTH{1'b1}} >> amt) : '0;
        dout      = din >> amt;
        case (mode_t'(mode))
            MODE_SLL: dout = din << amt;
            MODE_SRA: dout = (din >> amt) | fill_mask;
`ifdef ROTATE_EN
            MODE_ROR: dout = (din >> amt) | (din << (WIDTH - int'(amt)));
`endif
            default:  dout = din >> amt;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts a latched operand by up to STEP bits per clock
// behind valid/ready handshakes. Define ROTATE_EN to enable rotate-right on mode 11.
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int AW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int SW = $clog2(STEP + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [AW-1:0]    rem_q, rem_d;
    logic [1:0]       mode_q, mode_d;
    logic             fill_q, fill_d;
    logic [SW-1:0]    step_amt;
    logic [WIDTH-1:0] step_out;

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .din  (work_q),
        .amt  (step_amt),
        .mode (mode_q),
        .fill (fill_q),
        .dout (step_out)
    );

    // Largest legal bite this cycle: min(STEP, remaining).
    always_comb begin
        if ({1'b0, rem_q} > (AW + 1)'(STEP)) begin
            step_amt = SW'(STEP);
        end else begin
            step_amt = SW'(rem_q);
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        res_d   = res_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    rem_d  = in_amt;
                    mode_d = in_mode;
                    fill_d = in_data[WIDTH-1];
                    if (in_amt == '0) begin
                        res_d   = in_data;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - AW'(step_amt);
                if (rem_d == '0) begin
                    res_d   = step_out;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            res_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            res_q   <= res_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
        end
    end

    // The result register only changes when a result is produced, so out_data
    // holds steady through backpressure and after the handshake.
    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = res_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: two instances (STEP=1 and STEP=4) checked
// against a bit-serial reference model through an expected-result queue.
module tb_seq_shifter;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    localparam int STEPS [2] = '{1, 4};

    logic        clk;
    logic        reset;
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic [4:0]  in_amt    [2];
    logic [1:0]  in_mode   [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        busy      [2];

    int   n_cmp = 0;
    int   n_mis = 0;
    exp_t sb[$];

    seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .in_amt    (in_amt[0]),
        .in_mode   (in_mode[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data[0]),
        .busy      (busy[0])
    );

    seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .in_amt    (in_amt[1]),
        .in_mode   (in_mode[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data[1]),
        .busy      (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [31:0] data, input logic [4:0] amt,
                                          input logic [1:0] mode);
        logic [31:0] r;
        logic        sgn;
        r   = data;
        sgn = data[31];
        for (int i = 0; i < int'(amt); i++) begin
            case (mode)
                2'b00: r = {r[30:0], 1'b0};
                2'b10: r = {sgn, r[31:1]};
`ifdef ROTATE_EN
                2'b11: r = {r[0], r[31:1]};
`endif
                default: r = {1'b0, r[31:1]};
            endcase
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one request on instance d, wait for its result, hold it for
    // `hold` cycles of backpressure, then complete the handshake. Entered at a negedge.
    task automatic run_op(input int d, input logic [31:0] data, input logic [4:0] amt,
                          input logic [1:0] mode, input int hold);
        exp_t        e;
        int          edges;
        logic [31:0] held;
        check("ready_before_accept", 32'(in_ready[d]), 32'd1);
        in_valid[d] = 1'b1;
        in_data[d]  = data;
        in_amt[d]   = amt;
        in_mode[d]  = mode;
        e.data = model(data, amt, mode);
        e.lat  = 1 + (int'(amt) + STEPS[d] - 1) / STEPS[d];
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = $urandom;
        in_amt[d]   = 5'($urandom);
        in_mode[d]  = 2'($urandom);
        edges = 1;
        while (!out_valid[d] && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        e = sb.pop_front();
        check("latency", 32'(edges), 32'(e.lat));
        check("result", out_data[d], e.data);
        check("ready_in_done", 32'(in_ready[d]), 32'd0);
        held = out_data[d];
        for (int i = 0; i < hold; i++) begin
            in_valid[d] = 1'b1;
            in_data[d]  = 32'h1234_5678;
            in_amt[d]   = 5'd3;
            @(negedge clk);
            check("bp_valid", 32'(out_valid[d]), 32'd1);
            check("bp_stable", out_data[d], held);
            check("bp_ready", 32'(in_ready[d]), 32'd0);
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        out_ready[d] = 1'b0;
        in_valid[d]  = 1'b0;
        check("post_hs_valid", 32'(out_valid[d]), 32'd0);
        check("post_hs_data", out_data[d], held);
        check("post_hs_ready", 32'(in_ready[d]), 32'd1);
        check("post_hs_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_data[d]   = '0;
            in_amt[d]    = '0;
            in_mode[d]   = '0;
            out_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_valid", 32'(out_valid[d]), 32'd0);
            check("rst_data", out_data[d], 32'd0);
            check("rst_ready", 32'(in_ready[d]), 32'd1);
            check("rst_busy", 32'(busy[d]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        // STEP=1 logical left shifts of 1
        run_op(0, 32'd1, 5'd2, 2'b00, 0);
        run_op(0, 32'd1, 5'd4, 2'b00, 0);
        run_op(0, 32'd1, 5'd8, 2'b00, 1);

        // STEP=4 arithmetic right shift with a sign-extending final partial step
        run_op(1, 32'h8000_0000, 5'd31, 2'b10, 0);

        // Zero amount passes the operand through in every mode
        for (int m = 0; m < 4; m++) begin
            run_op(0, 32'hDEAD_BEEF, 5'd0, 2'(m), 0);
            run_op(1, 32'hDEAD_BEEF, 5'd0, 2'(m), 0);
        end

        // Five cycles of backpressure, with a competing request held on in_valid
        run_op(1, 32'hF0F0_1234, 5'd13, 2'b01, 5);

        // Mode 11 on the low bit
        run_op(0, 32'h0000_0001, 5'd1, 2'b11, 0);
        run_op(1, 32'h0000_0001, 5'd1, 2'b11, 0);
        run_op(1, 32'h8765_4321, 5'd10, 2'b11, 0);

        // Reset in the middle of a shift aborts it
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h0000_FFFF;
        in_amt[0]   = 5'd20;
        in_mode[0]  = 2'b00;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        check("midop_busy", 32'(busy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(out_valid[0]), 32'd0);
        check("abort_data", out_data[0], 32'd0);
        check("abort_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(0, 32'h0000_FFFF, 5'd20, 2'b00, 0);

        // Mixed random traffic on both step sizes
        for (int i = 0; i < 6; i++) begin
            run_op(0, $urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
            run_op(1, $urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 2)));
        end
        run_op(1, 32'h9000_0001, 5'd7, 2'b10, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
